// File: rtl/window_scan_ctrl_if.sv
// Handshake, configuration and coordinate bundle between the scan controller
// and its start/done master; the controller attaches through the slave modport.
interface window_scan_ctrl_if #(
    parameter int ADDR_W   = 8,
    parameter int KSIZE_W  = 3,
    parameter int STRIDE_W = 3
);
    logic                  start;
    logic                  stall;
    logic [ADDR_W-1:0]     img_width;
    logic [ADDR_W-1:0]     img_height;
    logic [KSIZE_W-1:0]    k_size;
    logic [STRIDE_W-1:0]   stride;

    logic                  busy;
    logic                  win_valid;
    logic [ADDR_W-1:0]     win_row;
    logic [ADDR_W-1:0]     win_col;
    logic [KSIZE_W-1:0]    k_row;
    logic [KSIZE_W-1:0]    k_col;
    logic [2*ADDR_W-1:0]   addr;
    logic                  last;
    logic                  done;

    modport master (
        output start, stall, img_width, img_height, k_size, stride,
        input  busy, win_valid, win_row, win_col, k_row, k_col, addr, last, done
    );

    modport slave (
        input  start, stall, img_width, img_height, k_size, stride,
        output busy, win_valid, win_row, win_col, k_row, k_col, addr, last, done
    );
endinterface

// File: rtl/window_scan_ctrl.sv
// Sliding-window scan controller: four nested wrap-around counters emit one
// kernel-element coordinate per non-stalled cycle. Define WIN_SCAN_ADDR_EN to
// also generate the registered flat buffer address (otherwise addr is tied to 0).
module window_scan_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int KSIZE_W  = 3,
    parameter int STRIDE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    window_scan_ctrl_if.slave  bus
);
    localparam int AW2 = 2 * ADDR_W;
    localparam int CW  = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    width_q, width_d;
    logic [ADDR_W-1:0]    height_q, height_d;
    logic [KSIZE_W-1:0]   ksize_q, ksize_d;
    logic [STRIDE_W-1:0]  stride_q, stride_d;
    logic [ADDR_W-1:0]    win_row_q, win_row_d;
    logic [ADDR_W-1:0]    win_col_q, win_col_d;
    logic [KSIZE_W-1:0]   k_row_q, k_row_d;
    logic [KSIZE_W-1:0]   k_col_q, k_col_d;
    logic                 busy_q, busy_d;
    logic                 last_q, last_d;
    logic                 done_q, done_d;

    logic [KSIZE_W-1:0]   k_in;
    logic [STRIDE_W-1:0]  s_in;
    logic [KSIZE_W-1:0]   k_max_q;
    logic [CW-1:0]        col_span_q;
    logic                 col_wrap_q;
    logic [CW-1:0]        col_span_d;
    logic [CW-1:0]        row_span_d;
    logic [KSIZE_W-1:0]   k_max_d;

    assign k_in       = (bus.k_size == '0) ? KSIZE_W'(1) : bus.k_size;
    assign s_in       = (bus.stride == '0) ? STRIDE_W'(1) : bus.stride;
    assign k_max_q    = ksize_q - KSIZE_W'(1);
    assign col_span_q = CW'(win_col_q) + CW'(stride_q) + CW'(ksize_q);
    assign col_wrap_q = col_span_q > CW'(width_q);

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        ksize_d   = ksize_q;
        stride_d  = stride_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        k_row_d   = k_row_q;
        k_col_d   = k_col_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stall) begin
                    width_d   = bus.img_width;
                    height_d  = bus.img_height;
                    ksize_d   = k_in;
                    stride_d  = s_in;
                    win_row_d = '0;
                    win_col_d = '0;
                    k_row_d   = '0;
                    k_col_d   = '0;
                    // A kernel larger than the image fits no window at all.
                    if (CW'(k_in) > CW'(bus.img_width) || CW'(k_in) > CW'(bus.img_height)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!bus.stall) begin
                    if (last_q) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        win_row_d = '0;
                        win_col_d = '0;
                        k_row_d   = '0;
                        k_col_d   = '0;
                    end else if (k_col_q != k_max_q) begin
                        k_col_d = k_col_q + KSIZE_W'(1);
                    end else begin
                        k_col_d = '0;
                        if (k_row_q != k_max_q) begin
                            k_row_d = k_row_q + KSIZE_W'(1);
                        end else begin
                            k_row_d = '0;
                            if (col_wrap_q) begin
                                win_col_d = '0;
                                win_row_d = win_row_q + ADDR_W'(stride_q);
                            end else begin
                                win_col_d = win_col_q + ADDR_W'(stride_q);
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flag the final element one cycle ahead so last is registered with it.
        busy_d     = (state_d == SCAN);
        k_max_d    = ksize_d - KSIZE_W'(1);
        col_span_d = CW'(win_col_d) + CW'(stride_d) + CW'(ksize_d);
        row_span_d = CW'(win_row_d) + CW'(stride_d) + CW'(ksize_d);
        last_d     = busy_d && (k_col_d == k_max_d) && (k_row_d == k_max_d)
                     && (col_span_d > CW'(width_d)) && (row_span_d > CW'(height_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            ksize_q   <= KSIZE_W'(1);
            stride_q  <= STRIDE_W'(1);
            win_row_q <= '0;
            win_col_q <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
            busy_q    <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            ksize_q   <= ksize_d;
            stride_q  <= stride_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            k_row_q   <= k_row_d;
            k_col_q   <= k_col_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            done_q    <= done_d;
        end
    end

`ifdef WIN_SCAN_ADDR_EN
    logic [AW2-1:0] addr_q, addr_d;
    logic [AW2-1:0] row_base_d;

    always_comb begin
        row_base_d = AW2'(win_row_d) + AW2'(k_row_d);
        addr_d     = '0;
        if (busy_d) begin
            addr_d = row_base_d * AW2'(width_d) + AW2'(win_col_d) + AW2'(k_col_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign bus.addr = addr_q;
`else
    assign bus.addr = '0;
`endif

    // The registered element is withdrawn while the datapath is frozen; it is
    // presented again once stall drops, so nothing is lost or duplicated.
    assign bus.busy      = busy_q;
    assign bus.win_valid = busy_q & ~bus.stall;
    assign bus.last      = last_q & ~bus.stall;
    assign bus.done      = done_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.k_row     = k_row_q;
    assign bus.k_col     = k_col_q;
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: table of scan configurations, each
// checked element-by-element against a hand-written coordinate/address table.
module tb_window_scan_ctrl;
    logic clk;
    logic rst_n;

    window_scan_ctrl_if #(.ADDR_W(8), .KSIZE_W(3), .STRIDE_W(3)) bus ();

    window_scan_ctrl #(.ADDR_W(8), .KSIZE_W(3), .STRIDE_W(3)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int wr;
        int wc;
        int kr;
        int kc;
        int a;
    } elem_t;

    typedef struct {
        int w;
        int h;
        int k;
        int s;
        int first;
        int count;
        int stall_at;
        int pulse_at;
    } scan_t;

    elem_t elems[33];
    scan_t scans[6];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_addr(input int a);
`ifdef WIN_SCAN_ADDR_EN
        return a;
`else
        return 0 * a;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},      int'(bus.busy), 0);
        chk({tag, " win_valid"}, int'(bus.win_valid), 0);
        chk({tag, " last"},      int'(bus.last), 0);
        chk({tag, " done"},      int'(bus.done), 0);
        chk({tag, " win_row"},   int'(bus.win_row), 0);
        chk({tag, " win_col"},   int'(bus.win_col), 0);
        chk({tag, " k_row"},     int'(bus.k_row), 0);
        chk({tag, " k_col"},     int'(bus.k_col), 0);
        chk({tag, " addr"},      int'(bus.addr), 0);
    endtask

    // Start at edge t, then walk cycles t+1.. checking each presented element.
    task automatic run_scan(input int si);
        scan_t sc;
        int e;
        int stall_left;
        elem_t ex;
        sc = scans[si];
        @(posedge clk); #1;
        bus.img_width  = 8'(sc.w);
        bus.img_height = 8'(sc.h);
        bus.k_size     = 3'(sc.k);
        bus.stride     = 3'(sc.s);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.img_width  = 8'd7;
        bus.img_height = 8'd7;
        bus.k_size     = 3'd1;
        bus.stride     = 3'd1;
        e = 0;
        stall_left = 3;
        while (e < sc.count) begin
            bus.stall = (e == sc.stall_at) && (stall_left > 0);
            if (bus.stall) stall_left--;
            bus.start = (e == sc.pulse_at) && !bus.stall;
            #1;
            ex = elems[sc.first + e];
            chk("busy",      int'(bus.busy), 1);
            chk("win_valid", int'(bus.win_valid), bus.stall ? 0 : 1);
            chk("win_row",   int'(bus.win_row), ex.wr);
            chk("win_col",   int'(bus.win_col), ex.wc);
            chk("k_row",     int'(bus.k_row), ex.kr);
            chk("k_col",     int'(bus.k_col), ex.kc);
            chk("addr",      int'(bus.addr), exp_addr(ex.a));
            chk("last",      int'(bus.last), (!bus.stall && e == sc.count - 1) ? 1 : 0);
            chk("done",      int'(bus.done), 0);
            $display("scan %0d elem %0d stall=%0d row=%0d col=%0d kr=%0d kc=%0d addr=%0d last=%0d",
                     si, e, bus.stall, bus.win_row, bus.win_col, bus.k_row, bus.k_col,
                     bus.addr, bus.last);
            if (!bus.stall) e++;
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("done pulse",      int'(bus.done), 1);
        chk("busy at done",    int'(bus.busy), 0);
        chk("valid at done",   int'(bus.win_valid), 0);
        chk("last at done",    int'(bus.last), 0);
        $display("scan %0d complete: %0d elements, done=%0d", si, sc.count, bus.done);
        @(posedge clk); #2;
        chk("done one cycle", int'(bus.done), 0);
        chk("busy after done", int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 4x4, k=2, stride=2
        elems[0]  = '{0,0,0,0,0};   elems[1]  = '{0,0,0,1,1};
        elems[2]  = '{0,0,1,0,4};   elems[3]  = '{0,0,1,1,5};
        elems[4]  = '{0,2,0,0,2};   elems[5]  = '{0,2,0,1,3};
        elems[6]  = '{0,2,1,0,6};   elems[7]  = '{0,2,1,1,7};
        elems[8]  = '{2,0,0,0,8};   elems[9]  = '{2,0,0,1,9};
        elems[10] = '{2,0,1,0,12};  elems[11] = '{2,0,1,1,13};
        elems[12] = '{2,2,0,0,10};  elems[13] = '{2,2,0,1,11};
        elems[14] = '{2,2,1,0,14};  elems[15] = '{2,2,1,1,15};
        // 3x3, k=2, stride=1
        elems[16] = '{0,0,0,0,0};   elems[17] = '{0,0,0,1,1};
        elems[18] = '{0,0,1,0,3};   elems[19] = '{0,0,1,1,4};
        elems[20] = '{0,1,0,0,1};   elems[21] = '{0,1,0,1,2};
        elems[22] = '{0,1,1,0,4};   elems[23] = '{0,1,1,1,5};
        elems[24] = '{1,0,0,0,3};   elems[25] = '{1,0,0,1,4};
        elems[26] = '{1,0,1,0,6};   elems[27] = '{1,0,1,1,7};
        elems[28] = '{1,1,0,0,4};   elems[29] = '{1,1,0,1,5};
        elems[30] = '{1,1,1,0,7};   elems[31] = '{1,1,1,1,8};
        // 1x1, k=0 -> 1
        elems[32] = '{0,0,0,0,0};

        //          w  h  k  s  first count stall pulse
        scans[0] = '{4, 4, 2, 2, 0,  16, -1, -1};
        scans[1] = '{3, 3, 2, 0, 16, 16, -1, -1};
        scans[2] = '{3, 3, 2, 0, 16, 16,  5, -1};
        scans[3] = '{2, 5, 3, 1, 0,  0,  -1, -1};
        scans[4] = '{1, 1, 0, 0, 32, 1,  -1, -1};
        scans[5] = '{4, 4, 2, 2, 0,  16, -1,  3};

        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        bus.img_width  = '0;
        bus.img_height = '0;
        bus.k_size     = '0;
        bus.stride     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_scan(i);
        end

        // Reset asserted mid-scan: outputs clear at once, no done afterwards.
        @(posedge clk); #1;
        bus.img_width  = 8'd4;
        bus.img_height = 8'd4;
        bus.k_size     = 3'd2;
        bus.stride     = 3'd2;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("busy before abort", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("no done after abort", int'(bus.done), 0);
            chk("idle after abort", int'(bus.busy), 0);
        end
        run_scan(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
